tmr_scrub_mem: RTL and testbench
================================

# tmr_scrub_mem

Triple-modular-redundant memory with bitwise majority voting, read-triggered repair, and an autonomous background scrubber. Width, depth and scrub rate are parametrised. It replaces bench-driven scrub sweeps: the block repairs single-replica upsets on its own and counts corrected and uncorrectable words for system health monitoring. It sits between the host datapath and the triplicated storage, alongside the TMR counter logic in `top`.

## Interface
- DW, 8: data width in bits.
- AW, 6: address width; DEPTH = 2^AW words per replica.
- SCRUB_INTERVAL, 16: number of idle cycles between background scrub accesses; must be ≥ 1.
- CW, 16: width of each statistics counter.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  host write strobe.
- re  in  1  host read strobe.
- addr  in  AW  host address.
- wdata  in  DW  host write data.
- rdata  out  DW  voted read data; registered.
- rvalid  out  1  pulses high for one cycle while rdata holds a host read result.
- scrub_en  in  1  enables the background scrubber.
- clr_stats  in  1  synchronous clear of both statistics counters.
- corr_cnt  out  CW  saturating count of corrected words.
- uncorr_cnt  out  CW  saturating count of uncorrectable words.
- uncorr  out  1  pulses for one cycle when an uncorrectable word is detected.
- scrub_ptr  out  AW  next address the scrubber will visit.
- scrub_wrap  out  1  pulses for one cycle when the scrubber completes a full sweep.

## Operation
- Storage is three arrays, mem0, mem1 and mem2, each DEPTH×DW.
  - These hierarchical names are fixed so benches can inject faults.
  - Arrays are not reset.
- Word classification for address A, where r0, r1, r2 are the replica words:
  - clean: all three equal.
  - correctable: exactly two replicas equal.
  - uncorrectable: no two replicas equal.
  - voted value v = (r0&r1)|(r1&r2)|(r0&r2).
- Host write (we=1): wdata is written to all three replicas at A. A write takes priority over any other activity in that cycle.
- Host read (re=1, we=0):
  - Next cycle: rdata=v and rvalid=1.
  - correctable: v is written back to all three replicas on the same edge, and corr_cnt increments.
  - uncorrectable: no write-back, uncorr pulses, uncorr_cnt increments, and rdata is still v.
- we=1 and re=1 together: the write is performed, the read returns pre-write data (read-before-write), and repair is suppressed.
- Scrubber FSM:
  - OFF: scrub_en=0. Interval counter held at 0, scrub_ptr held.
  - COUNT: on each idle cycle (we=0, re=0) the counter increments. It moves to DUE when the counter reaches SCRUB_INTERVAL-1 on an idle cycle.
  - DUE: on the first idle cycle, the scrubber classifies and repairs scrub_ptr using the same rules and counters as a host read, but with no rvalid. Then scrub_ptr increments, the counter clears, and the FSM returns to COUNT. Host accesses in DUE defer the scrub; they are never preempted.
  - Any state → OFF when scrub_en=0; the counter clears and scrub_ptr is retained.
- scrub_ptr wraps DEPTH-1 → 0; scrub_wrap pulses on the edge where the wrap occurs.
- Counters saturate at 2^CW-1.
  - clr_stats=1 zeroes both counters and wins over a simultaneous increment.
  - At most one event occurs per cycle, since host access and scrub are mutually exclusive.

## Timing
- Reset values: rdata=0, rvalid=0, uncorr=0, scrub_wrap=0, corr_cnt=0, uncorr_cnt=0, scrub_ptr=0. FSM starts in OFF with counter 0.
- Read latency is 1 cycle: re sampled at edge k gives rdata/rvalid valid after edge k, for one cycle.
- Repair write, counter update and uncorr pulse all occur on the same edge as the rdata update (read) or the scrub visit.
- Back-to-back reads are supported every cycle.
- A read of A in cycle k+1 after a repair of A at edge k returns clean data.
- Repair uses the read address registered from the read cycle; a host write in the following cycle is unaffected.
- rst asserted mid-operation:
  - All outputs and the FSM clear immediately.
  - Any in-flight repair is abandoned.
  - Array contents are left as they were.

## Test plan
- Write 0x5A to addr 3 and read it back → rvalid one cycle after re, rdata=0x5A, corr_cnt=0.
- Write 0x5A to addr 3, flip mem1[3] bit 2, then read addr 3 → rdata=0x5A and corr_cnt=1. An immediate re-read leaves corr_cnt=1, and mem1[3]=0x5A.
- Write 0x00 to addr 7, set mem0[7]=0x01 and mem1[7]=0x02, then read addr 7 → rdata=0x00 (bitwise vote), uncorr pulse, uncorr_cnt=1, no replica modified.
- AW=6, SCRUB_INTERVAL=4, scrub_en=1, host idle, flip mem2[10] bit 0 → the scrubber repairs it within 4·11 cycles, corr_cnt=1, and scrub_wrap pulses after 256 cycles with scrub_ptr=0.
- Continuous host reads while scrub_en=1 → scrub_ptr never advances. When idle resumes, the first scrub happens on the next idle cycle (DUE held).
- Assert rst mid-sweep with scrub_ptr=20 and corr_cnt=5 → all outputs 0, memory data preserved. Assert clr_stats coincident with a correctable read → corr_cnt=0.

Source files
------------

// File: rtl/tmr_scrub_mem.sv
// Triplicated word memory with bitwise majority vote, repair on host read and a
// background scrubber that walks every address and fixes single-replica upsets.
`timescale 1ns/1ps
module tmr_scrub_mem #(
  parameter int DW             = 8,
  parameter int AW             = 6,
  parameter int SCRUB_INTERVAL = 16,
  parameter int CW             = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  input  logic          scrub_en,
  input  logic          clr_stats,
  output logic [CW-1:0] corr_cnt,
  output logic [CW-1:0] uncorr_cnt,
  output logic          uncorr,
  output logic [AW-1:0] scrub_ptr,
  output logic          scrub_wrap,
  output logic [1:0]    dbg_state_o
);
  localparam int DEPTH = 1 << AW;
  localparam int ICW   = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [ICW-1:0] LAST_CNT = ICW'(SCRUB_INTERVAL - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_COUNT = 2'd1,
    S_DUE   = 2'd2
  } state_e;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];

  state_e          state_q;
  logic [ICW-1:0]  icnt_q;
  logic [AW-1:0]   ptr_q;
  logic            wrap_q;
  logic [DW-1:0]   rdata_q;
  logic            rvalid_q;
  logic            uncorr_q;
  logic [CW-1:0]   corr_q, corr_d;
  logic [CW-1:0]   ucnt_q, ucnt_d;

  logic [AW-1:0] chk_addr, mem_addr;
  logic [DW-1:0] r0, r1, r2, vote, mem_wdata;
  logic          clean, two_eq, idle, host_rd, scrub_go, chk;
  logic          corr_evt, uncorr_evt, mem_we;

  // Host access wins the single shared array port; the scrubber only uses idle cycles.
  assign idle      = ~we & ~re;
  assign host_rd   = re & ~we;
  assign scrub_go  = (state_q == S_DUE) & scrub_en & idle;
  assign chk_addr  = re ? addr : ptr_q;

  assign r0     = mem0[chk_addr];
  assign r1     = mem1[chk_addr];
  assign r2     = mem2[chk_addr];
  assign vote   = (r0 & r1) | (r1 & r2) | (r0 & r2);
  assign clean  = (r0 == r1) && (r1 == r2);
  assign two_eq = (r0 == r1) || (r1 == r2) || (r0 == r2);

  assign chk        = host_rd | scrub_go;
  assign corr_evt   = chk & two_eq & ~clean;
  assign uncorr_evt = chk & ~two_eq;

  assign mem_we    = we | corr_evt;
  assign mem_addr  = we ? addr : chk_addr;
  assign mem_wdata = we ? wdata : vote;

  // Writes are gated by rst so a repair in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem0[mem_addr] <= mem_wdata;
      mem1[mem_addr] <= mem_wdata;
      mem2[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      icnt_q  <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!scrub_en) begin
        state_q <= S_OFF;
        icnt_q  <= '0;
      end else begin
        case (state_q)
          S_OFF, S_COUNT: begin
            if (SCRUB_INTERVAL == 1) begin
              state_q <= S_DUE;
            end else if (idle) begin
              icnt_q  <= icnt_q + 1'b1;
              state_q <= (icnt_q + 1'b1 == LAST_CNT) ? S_DUE : S_COUNT;
            end else begin
              state_q <= S_COUNT;
            end
          end
          S_DUE: begin
            if (idle) begin
              ptr_q   <= ptr_q + 1'b1;
              icnt_q  <= '0;
              wrap_q  <= (ptr_q == AW'(DEPTH - 1));
              state_q <= (SCRUB_INTERVAL == 1) ? S_DUE : S_COUNT;
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  always_comb begin
    corr_d = corr_q;
    ucnt_d = ucnt_q;
    if (clr_stats) begin
      corr_d = '0;
      ucnt_d = '0;
    end else begin
      if (corr_evt && (corr_q != '1))   corr_d = corr_q + 1'b1;
      if (uncorr_evt && (ucnt_q != '1)) ucnt_d = ucnt_q + 1'b1;
    end
  end

  // rvalid is a one-cycle qualifier for rdata with no back-pressure: the host must take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      uncorr_q <= 1'b0;
      corr_q   <= '0;
      ucnt_q   <= '0;
    end else begin
      rvalid_q <= re;
      if (re) rdata_q <= vote;
      uncorr_q <= uncorr_evt;
      corr_q   <= corr_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign uncorr      = uncorr_q;
  assign corr_cnt    = corr_q;
  assign uncorr_cnt  = ucnt_q;
  assign scrub_ptr   = ptr_q;
  assign scrub_wrap  = wrap_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_tmr_scrub_mem.sv
// Directed bench for tmr_scrub_mem: host read/repair, uncorrectable words,
// read-before-write, saturation, stats clear, background scrub and async reset.
`timescale 1ns/1ps
module tb_tmr_scrub_mem;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int SI = 4;
  localparam int CW = 4;
  localparam int DEPTH = 1 << AW;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          we, re, scrub_en, clr_stats;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid, uncorr, scrub_wrap;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  logic [AW-1:0] scrub_ptr;
  logic [1:0]    state_dbg;

  tmr_scrub_mem #(.DW(DW), .AW(AW), .SCRUB_INTERVAL(SI), .CW(CW)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .scrub_en(scrub_en), .clr_stats(clr_stats),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .uncorr(uncorr),
    .scrub_ptr(scrub_ptr), .scrub_wrap(scrub_wrap), .dbg_state_o(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int corr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; addr = a; wdata = d;
    model[a] = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    re = 1'b1; addr = a;
    exp_q.push_back(model[a]);
    tick();
    re = 1'b0;
  endtask

  // scoreboard: every rvalid must match the oldest outstanding read
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) check("spurious_rvalid", 32'(rvalid), 32'd0);
      else check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [AW-1:0] a, p;
    logic [DW-1:0] d, mask, bad50;
    int r;

    rst = 1'b1; we = 1'b0; re = 1'b0; scrub_en = 1'b0; clr_stats = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", 32'(rdata), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_uncorr", 32'(uncorr), 0);
    check("rst_wrap", 32'(scrub_wrap), 0);
    check("rst_corr_cnt", 32'(corr_cnt), 0);
    check("rst_uncorr_cnt", 32'(uncorr_cnt), 0);
    check("rst_ptr", 32'(scrub_ptr), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom_range(0, 255)));

    // plain write / read
    do_write(6'd3, 8'h5A);
    do_read(6'd3);
    check("rvalid_after_re", 32'(rvalid), 1);
    check("corr_clean", 32'(corr_cnt), 0);
    tick();
    check("rvalid_one_cycle", 32'(rvalid), 0);

    // single-replica upset repaired by a host read
    dut.mem1[3] = dut.mem1[3] ^ 8'h04;
    do_read(6'd3);
    corr_m = 1;
    check("corr_after_repair", 32'(corr_cnt), 32'(corr_m));
    check("mem1_repaired", 32'(dut.mem1[3]), 32'h5A);
    do_read(6'd3);
    check("corr_reread", 32'(corr_cnt), 32'(corr_m));

    // uncorrectable word: bitwise vote, no write-back
    do_write(6'd7, 8'h00);
    dut.mem0[7] = 8'h01;
    dut.mem1[7] = 8'h02;
    do_read(6'd7);
    check("uncorr_pulse", 32'(uncorr), 1);
    check("uncorr_cnt", 32'(uncorr_cnt), 1);
    check("uncorr_mem0", 32'(dut.mem0[7]), 32'h01);
    check("uncorr_mem1", 32'(dut.mem1[7]), 32'h02);
    check("uncorr_mem2", 32'(dut.mem2[7]), 32'h00);
    tick();
    check("uncorr_pulse_end", 32'(uncorr), 0);

    // simultaneous write+read: old data returned, no repair counted
    dut.mem0[3] = 8'hFF;
    we = 1'b1; re = 1'b1; addr = 6'd3; wdata = 8'h33;
    exp_q.push_back(model[3]);
    tick();
    model[3] = 8'h33;
    we = 1'b0; re = 1'b0;
    check("rbw_no_repair", 32'(corr_cnt), 32'(corr_m));
    check("rbw_mem0", 32'(dut.mem0[3]), 32'h33);
    do_read(6'd3);

    // random single-replica upsets, counter saturates at 2^CW-1
    for (int i = 0; i < 16; i++) begin
      a = AW'($urandom_range(16, 31));
      d = DW'($urandom_range(0, 255));
      do_write(a, d);
      r = $urandom_range(0, 2);
      mask = DW'($urandom_range(1, 255));
      case (r)
        0: dut.mem0[a] = dut.mem0[a] ^ mask;
        1: dut.mem1[a] = dut.mem1[a] ^ mask;
        default: dut.mem2[a] = dut.mem2[a] ^ mask;
      endcase
      do_read(a);
      corr_m = (corr_m == (1 << CW) - 1) ? corr_m : corr_m + 1;
      check("corr_sat", 32'(corr_cnt), 32'(corr_m));
    end
    check("uncorr_cnt_stable", 32'(uncorr_cnt), 1);

    // back-to-back reads
    do_read(6'd3);
    do_read(6'd5);
    do_read(6'd6);

    // clear wins over a simultaneous correctable read
    dut.mem2[20] = dut.mem2[20] ^ 8'h80;
    clr_stats = 1'b1; re = 1'b1; addr = 6'd20;
    exp_q.push_back(model[20]);
    tick();
    clr_stats = 1'b0; re = 1'b0;
    corr_m = 0;
    check("clr_corr", 32'(corr_cnt), 0);
    check("clr_uncorr", 32'(uncorr_cnt), 0);
    check("clr_still_repairs", 32'(dut.mem2[20]), 32'(model[20]));

    // background scrub sweep
    do_write(6'd7, 8'h77);
    do_write(6'd10, 8'h10);
    dut.mem2[10] = dut.mem2[10] ^ 8'h01;
    scrub_en = 1'b1;
    cyc = 0;
    while (corr_cnt == 0 && cyc < 60) begin tick(); cyc++; end
    check("scrub_repair_cycle", 32'(cyc), 44);
    check("scrub_ptr_after_10", 32'(scrub_ptr), 11);
    check("scrub_mem2_fixed", 32'(dut.mem2[10]), 32'h10);
    while (scrub_wrap !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    check("wrap_cycle", 32'(cyc), 256);
    check("wrap_ptr", 32'(scrub_ptr), 0);
    check("wrap_corr", 32'(corr_cnt), 1);
    check("wrap_uncorr", 32'(uncorr_cnt), 0);

    // host reads hold a due scrub
    cyc = 0;
    while (state_dbg !== 2'd2 && cyc < 20) begin tick(); cyc++; end
    check("reach_due", 32'(state_dbg), 2);
    p = scrub_ptr;
    for (int i = 0; i < 10; i++) do_read(6'd5);
    check("ptr_held_by_reads", 32'(scrub_ptr), 32'(p));
    check("due_held", 32'(state_dbg), 2);
    tick();
    check("scrub_after_idle", 32'(scrub_ptr), 32'(AW'(p + 1)));

    // build corr_cnt=5 then reset mid-sweep at scrub_ptr=20
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = AW'(40 + i);
      dut.mem1[a] = dut.mem1[a] ^ 8'h11;
      do_read(a);
    end
    check("corr_five", 32'(corr_cnt), 5);
    cyc = 0;
    while (scrub_ptr != 6'd20 && cyc < 200) begin tick(); cyc++; end
    check("ptr_twenty", 32'(scrub_ptr), 20);
    check("corr_five_before_rst", 32'(corr_cnt), 5);
    dut.mem1[50] = dut.mem1[50] ^ 8'h08;
    bad50 = model[50] ^ 8'h08;
    #2 rst = 1'b1;
    #1;
    check("arst_ptr", 32'(scrub_ptr), 0);
    check("arst_corr", 32'(corr_cnt), 0);
    check("arst_uncorr_cnt", 32'(uncorr_cnt), 0);
    check("arst_rdata", 32'(rdata), 0);
    check("arst_rvalid", 32'(rvalid), 0);
    check("arst_state", 32'(state_dbg), 0);
    tick();
    scrub_en = 1'b0;
    tick();
    rst = 1'b0;
    check("arst_mem0_kept", 32'(dut.mem0[50]), 32'(model[50]));
    check("arst_mem1_kept", 32'(dut.mem1[50]), 32'(bad50));
    check("arst_mem_10", 32'(dut.mem0[10]), 32'h10);
    do_read(6'd50);
    check("post_rst_repair", 32'(corr_cnt), 1);
    tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
